voice_envelope: RTL and testbench

- Per-voice ADSR envelope generator for the 8-voice synth engine.
- Sits directly downstream of the note sequencer/override stage and consumes its per-voice gate vector (on_out → on_in).
- Produces a per-voice amplitude level and an active flag, which the oscillator/mixer stage uses for gain scaling and voice allocation.
- Uses one shared arithmetic datapath, time-multiplexed across voices in a sweep triggered by a periodic tick.

---
 rtl/voice_envelope_if.sv | 13 +
 rtl/voice_envelope.sv | 148 ++++++++++++++
 tb/tb_voice_envelope.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_envelope_if.sv
// Voice envelope bus: sequencer gate vector in, per-voice levels/activity and sweep pulse out.
interface voice_envelope_if #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned ENV_WIDTH  = 16
);
  logic [NUM_VOICES-1:0]                on_in;
  logic [NUM_VOICES-1:0][ENV_WIDTH-1:0] env_out;
  logic [NUM_VOICES-1:0]                active_out;
  logic                                 sweep_done;

  modport master (output on_in, input env_out, active_out, sweep_done);
  modport slave  (input on_in, output env_out, active_out, sweep_done);
endinterface

// File: rtl/voice_envelope.sv
// Per-voice ADSR envelope generator with one shared datapath swept across voices each tick.
// Define VOICE_ENVELOPE_HARD_RETRIG_EN to restart ATTACK from 0 on every trigger.
module voice_envelope #(
  parameter int unsigned NUM_VOICES    = 8,
  parameter int unsigned ENV_WIDTH     = 16,
  parameter int unsigned TICK_DIV      = 50000,
  parameter int unsigned ATTACK_STEP   = 64,
  parameter int unsigned DECAY_STEP    = 16,
  parameter int unsigned SUSTAIN_LEVEL = 49152,
  parameter int unsigned RELEASE_STEP  = 32
) (
  input  logic           clk,
  input  logic           rst,
  voice_envelope_if.slave bus
);
  localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LW = ENV_WIDTH + 1;
  localparam logic [LW-1:0] MAX_L = {1'b0, {ENV_WIDTH{1'b1}}};
  localparam logic [LW-1:0] ATK_L = LW'(ATTACK_STEP);
  localparam logic [LW-1:0] DEC_L = LW'(DECAY_STEP);
  localparam logic [LW-1:0] SUS_L = LW'(SUSTAIN_LEVEL);
  localparam logic [LW-1:0] REL_L = LW'(RELEASE_STEP);
  localparam logic [IW-1:0] LAST  = IW'(NUM_VOICES - 1);
  localparam logic [PW-1:0] TOP   = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ATTACK, S_DECAY, S_SUSTAIN, S_RELEASE
  } env_state_t;

  env_state_t            state_q [NUM_VOICES];
  logic [ENV_WIDTH-1:0]  level_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_prev_q, pending_q, pending_nxt, rise;
  logic [PW-1:0]         presc_q;
  logic [IW-1:0]         idx_q;
  logic                  sweep_q, last_wr_q, done_q, tick;

  env_state_t            cur_state, eff_state, nxt_state;
  logic [LW-1:0]         base, res;
  logic [ENV_WIDTH-1:0]  nxt_level;
  logic                  trig;

  assign tick = (presc_q == TOP);

  always_comb begin
    rise      = bus.on_in & ~gate_prev_q;
    cur_state = state_q[idx_q];
    base      = {1'b0, level_q[idx_q]};
    trig      = pending_q[idx_q] | rise[idx_q];
    eff_state = cur_state;
    res       = base;
    nxt_state = cur_state;
    // A trigger or gate drop redirects the state first; the step of the new state applies in this same slot.
    if (trig) begin
      eff_state = S_ATTACK;
`ifdef VOICE_ENVELOPE_HARD_RETRIG_EN
      base = '0;
`endif
    end else if (!bus.on_in[idx_q] && (cur_state inside {S_ATTACK, S_DECAY, S_SUSTAIN})) begin
      eff_state = S_RELEASE;
    end
    case (eff_state)
      S_IDLE: begin
        res       = '0;
        nxt_state = S_IDLE;
      end
      S_ATTACK: begin
        res       = base + ATK_L;
        nxt_state = S_ATTACK;
        if (res >= MAX_L) begin
          res       = MAX_L;
          nxt_state = S_DECAY;
        end
      end
      S_DECAY: begin
        if (base >= SUS_L + DEC_L) res = base - DEC_L;
        else                       res = SUS_L;
        nxt_state = (res == SUS_L) ? S_SUSTAIN : S_DECAY;
      end
      S_SUSTAIN: begin
        res       = base;
        nxt_state = S_SUSTAIN;
      end
      S_RELEASE: begin
        if (base > REL_L) begin
          res       = base - REL_L;
          nxt_state = S_RELEASE;
        end else begin
          res       = '0;
          nxt_state = S_IDLE;
        end
      end
      default: begin
        res       = '0;
        nxt_state = S_IDLE;
      end
    endcase
    nxt_level   = res[ENV_WIDTH-1:0];
    pending_nxt = pending_q | rise;
    if (sweep_q) pending_nxt[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= S_IDLE;
        level_q[i] <= '0;
      end
    end else if (sweep_q) begin
      state_q[idx_q] <= nxt_state;
      level_q[idx_q] <= nxt_level;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      sweep_q     <= 1'b0;
      idx_q       <= '0;
      last_wr_q   <= 1'b0;
      done_q      <= 1'b0;
      gate_prev_q <= '0;
      pending_q   <= '0;
    end else begin
      gate_prev_q <= bus.on_in;
      pending_q   <= pending_nxt;
      presc_q     <= tick ? '0 : presc_q + 1'b1;
      last_wr_q   <= sweep_q && (idx_q == LAST);
      done_q      <= last_wr_q;
      if (tick) begin
        sweep_q <= 1'b1;
        idx_q   <= '0;
      end else if (sweep_q) begin
        if (idx_q == LAST) sweep_q <= 1'b0;
        else               idx_q   <= idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      bus.env_out[i]    = level_q[i];
      bus.active_out[i] = (state_q[i] != S_IDLE);
    end
  end

  assign bus.sweep_done = done_q;
endmodule

// File: tb/tb_voice_envelope.sv
// Self-checking bench for voice_envelope against a cycle-counted behavioural envelope model.
`timescale 1ns/1ps
module tb_voice_envelope;
  localparam int NV = 8, EW = 16, TICK = 16;
  localparam int ATK = 4096, DEC = 1024, SUS = 49152, REL = 2048, MAXV = 65535;
  localparam int DONE0 = TICK + NV + 1;
  localparam int M_IDLE = 0, M_ATK = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0, n_fail = 0;

  voice_envelope_if #(.NUM_VOICES(NV), .ENV_WIDTH(EW)) bus ();

  voice_envelope #(
    .NUM_VOICES(NV), .ENV_WIDTH(EW), .TICK_DIV(TICK), .ATTACK_STEP(ATK),
    .DECAY_STEP(DEC), .SUSTAIN_LEVEL(SUS), .RELEASE_STEP(REL)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: voice (cycle mod TICK) is updated in cycles TICK.. of each period.
  int m_level[NV];
  int m_state[NV];
  bit [NV-1:0] m_pend, m_prev, m_rise;
  int m_cyc, m_slot;

  function automatic void model_voice(int v, bit trig, bit gate);
    int lvl, st;
    lvl = m_level[v];
    st  = m_state[v];
    if (trig) begin
      st = M_ATK;
`ifdef VOICE_ENVELOPE_HARD_RETRIG_EN
      lvl = 0;
`endif
    end else if (!gate && (st == M_ATK || st == M_DEC || st == M_SUS)) st = M_REL;
    case (st)
      M_IDLE: lvl = 0;
      M_ATK:  begin lvl += ATK; if (lvl >= MAXV) begin lvl = MAXV; st = M_DEC; end end
      M_DEC:  begin lvl -= DEC; if (lvl <= SUS) begin lvl = SUS; st = M_SUS; end end
      M_REL:  begin lvl -= REL; if (lvl <= 0) begin lvl = 0; st = M_IDLE; end end
      default: ;
    endcase
    m_level[v] = lvl;
    m_state[v] = st;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NV; v++) begin m_level[v] = 0; m_state[v] = M_IDLE; end
      m_pend = '0; m_prev = '0; m_cyc = 0;
    end else begin
      m_rise = bus.on_in & ~m_prev;
      m_slot = m_cyc % TICK;
      if (m_cyc >= TICK && m_slot < NV) begin
        model_voice(m_slot, m_pend[m_slot] | m_rise[m_slot], bus.on_in[m_slot]);
        m_pend[m_slot] = 1'b0;
        m_rise[m_slot] = 1'b0;
      end
      m_pend |= m_rise;
      m_prev = bus.on_in;
      m_cyc++;
    end
  end

  function automatic bit exp_done();
    return (m_cyc >= DONE0) && (((m_cyc - DONE0) % TICK) == 0);
  endfunction

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * TICK && !ok; i++) begin
      @(negedge clk);
      if (bus.sweep_done === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL sweep_timeout: no sweep_done within %0d cycles", 3 * TICK);
    end
  endtask

  task automatic test_reset();
    int first;
    rst = 1'b1;
    bus.on_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.env_out !== '0 || bus.active_out !== '0 || bus.sweep_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: env=%h active=%b done=%b required all zero",
               bus.env_out, bus.active_out, bus.sweep_done);
    end
    rst = 1'b0;
    first = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.sweep_done !== exp_done()) begin
        n_fail++;
        $display("FAIL idle_sweep_done: cycle %0d got %b required %b", c, bus.sweep_done, exp_done());
      end
      if (bus.sweep_done === 1'b1 && first < 0) first = c;
      n_cmp++;
      if (bus.env_out !== '0 || bus.active_out !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs: cycle %0d env=%h active=%b required zero", c, bus.env_out, bus.active_out);
      end
    end
    n_cmp++;
    if (first !== 25) begin
      n_fail++;
      $display("FAIL first_done: first pulse at cycle %0d required 25", first);
    end
  endtask

  task automatic test_attack_decay();
    bit ok;
    wait_done(ok);
    bus.on_in[0] = 1'b1;
    for (int u = 1; u <= 34; u++) begin
      wait_done(ok);
      n_cmp++;
      if (int'(bus.env_out[0]) !== m_level[0] || bus.active_out[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL attack_decay_level: update %0d env=%0d active=%b required %0d active 1",
                 u, bus.env_out[0], bus.active_out[0], m_level[0]);
      end
      if (u == 16 || u >= 32) begin
        n_cmp++;
        if (int'(bus.env_out[0]) !== ((u == 16) ? MAXV : SUS)) begin
          n_fail++;
          $display("FAIL attack_decay_boundary: update %0d env=%0d required %0d",
                   u, bus.env_out[0], (u == 16) ? MAXV : SUS);
        end
      end
    end
  endtask

  task automatic test_release();
    int u;
    u = 0;
    bus.on_in[0] = 1'b0;
    for (int c = 0; c < 26 * TICK && u < 24; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.active_out[0] !== (bus.env_out[0] != '0)) begin
        n_fail++;
        $display("FAIL release_active_track: env=%0d active=%b", bus.env_out[0], bus.active_out[0]);
      end
      if (bus.sweep_done === 1'b1) begin
        u++;
        n_cmp++;
        if (int'(bus.env_out[0]) !== m_level[0] || (u == 1 && int'(bus.env_out[0]) !== 47104)) begin
          n_fail++;
          $display("FAIL release_level: update %0d env=%0d required %0d", u, bus.env_out[0], m_level[0]);
        end
      end
    end
    n_cmp++;
    if (u !== 24 || bus.env_out[0] !== '0 || bus.active_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL release_end: updates=%0d env=%0d active=%b required 24 updates, 0, 0",
               u, bus.env_out[0], bus.active_out[0]);
    end
  endtask

  task automatic test_short_pulse();
    bit ok;
    int exp_l[3] = '{4096, 2048, 0};
    bit exp_a[3] = '{1'b1, 1'b1, 1'b0};
    wait_done(ok);
    repeat (2) @(negedge clk);
    bus.on_in[3] = 1'b1;
    repeat (2) @(negedge clk);
    bus.on_in[3] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      wait_done(ok);
      n_cmp++;
      if (int'(bus.env_out[3]) !== exp_l[s] || bus.active_out[3] !== exp_a[s] || m_level[3] !== exp_l[s]) begin
        n_fail++;
        $display("FAIL short_pulse: sweep %0d env=%0d active=%b required %0d active %b",
                 s, bus.env_out[3], bus.active_out[3], exp_l[s], exp_a[s]);
      end
    end
  endtask

  task automatic test_toggle();
    bit ok;
    int rv, first;
    for (int p = 0; p < 6; p++) begin
      rv = p % 2;
      bus.on_in[0] = (rv == 0);
      bus.on_in[1] = (rv == 1);
`ifdef VOICE_ENVELOPE_HARD_RETRIG_EN
      first = ATK;
`else
      first = (m_level[rv] + ATK > MAXV) ? MAXV : m_level[rv] + ATK;
`endif
      for (int s = 1; s <= 4; s++) begin
        wait_done(ok);
        n_cmp++;
        if (int'(bus.env_out[0]) !== m_level[0] || int'(bus.env_out[1]) !== m_level[1]) begin
          n_fail++;
          $display("FAIL toggle_levels: phase %0d sweep %0d env0=%0d env1=%0d required %0d %0d",
                   p, s, bus.env_out[0], bus.env_out[1], m_level[0], m_level[1]);
        end
        if (s == 1) begin
          n_cmp++;
          if (int'(bus.env_out[rv]) !== first) begin
            n_fail++;
            $display("FAIL toggle_retrigger: phase %0d voice %0d env=%0d required %0d",
                     p, rv, bus.env_out[rv], first);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int seg = 0; seg < 14; seg++) begin
      bus.on_in = NV'($urandom);
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : $urandom_range(100, 600);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        for (int v = 0; v < NV; v++) begin
          n_cmp++;
          if (int'(bus.env_out[v]) !== m_level[v] || bus.active_out[v] !== (m_state[v] != M_IDLE)) begin
            n_fail++;
            $display("FAIL random_voice: cycle %0d voice %0d env=%0d active=%b required %0d active %b",
                     m_cyc, v, bus.env_out[v], bus.active_out[v], m_level[v], m_state[v] != M_IDLE);
          end
        end
        n_cmp++;
        if (bus.sweep_done !== exp_done()) begin
          n_fail++;
          $display("FAIL random_done: cycle %0d got %b required %b", m_cyc, bus.sweep_done, exp_done());
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit ok;
    bus.on_in = '1;
    repeat (3) wait_done(ok);
    // From the pulse cycle (slot 9) ten edges lands in sweep slot 3.
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.env_out !== '0 || bus.active_out !== '0 || bus.sweep_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midsweep_reset_async: env=%h active=%b done=%b required all zero",
               bus.env_out, bus.active_out, bus.sweep_done);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.sweep_done !== 1'b0 || bus.env_out !== '0) begin
        n_fail++;
        $display("FAIL midsweep_reset_hold: cycle %0d done=%b env=%h required 0", c, bus.sweep_done, bus.env_out);
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.sweep_done !== exp_done() || int'(bus.env_out[5]) !== m_level[5]) begin
        n_fail++;
        $display("FAIL midsweep_restart: cycle %0d done=%b env5=%0d required %b %0d",
                 c, bus.sweep_done, bus.env_out[5], exp_done(), m_level[5]);
      end
    end
  endtask

  initial begin
    bus.on_in = '0;
    test_reset();
    test_attack_decay();
    test_release();
    test_short_pulse();
    test_toggle();
    test_random();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
